cycle_countdown_ctrl: RTL and testbench

Loadable down-counting cycle timer for the processor's multicycle units (multdiv, plotter step timing), the consumer-side counterpart to the free-running up counters. A requester loads a cycle count through a ready/start handshake. The block counts it down on `clk` rising edges, with hold and abort controls. It reports completion with a one-cycle `done` pulse. All outputs are registered.

---
 rtl/cycle_countdown_ctrl.sv | 113 +++++++++++
 tb/tb_cycle_countdown_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/cycle_countdown_ctrl.sv
// Loadable down-counting cycle timer with ready/start handshake, hold, abort and one-cycle done pulse.
// Optional periodic reload from DONE is enabled by defining CYCLE_COUNTDOWN_AUTORELOAD_EN.
//
// state | meaning
// IDLE  | waiting for start, ready=1
// RUN   | counting down, busy=1
// DONE  | one-cycle completion, done=1, count=0
module cycle_countdown_ctrl #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] load_val,
  input  logic             hold,
  input  logic             abort,
  output logic             ready,
  output logic             busy,
  output logic [WIDTH-1:0] count,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t state;

`ifdef CYCLE_COUNTDOWN_AUTORELOAD_EN
  logic [WIDTH-1:0] reload;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      count <= '0;
      ready <= 1'b1;
      busy  <= 1'b0;
      done  <= 1'b0;
`ifdef CYCLE_COUNTDOWN_AUTORELOAD_EN
      reload <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            count <= load_val;
            ready <= 1'b0;
`ifdef CYCLE_COUNTDOWN_AUTORELOAD_EN
            reload <= load_val;
`endif
            if (load_val != '0) begin
              state <= RUN;
              busy  <= 1'b1;
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end

        RUN: begin
          if (abort) begin
            state <= IDLE;
            count <= '0;
            ready <= 1'b1;
            busy  <= 1'b0;
          end else if (!hold) begin
            // <= rather than == so a corrupted zero count still terminates
            if (count <= WIDTH'(1)) begin
              state <= DONE;
              count <= '0;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              count <= count - 1'b1;
            end
          end
        end

        DONE: begin
          done <= 1'b0;
`ifdef CYCLE_COUNTDOWN_AUTORELOAD_EN
          if (!abort && reload != '0) begin
            state <= RUN;
            count <= reload;
            busy  <= 1'b1;
          end else begin
            state <= IDLE;
            count <= '0;
            ready <= 1'b1;
          end
`else
          state <= IDLE;
          count <= '0;
          ready <= 1'b1;
`endif
        end

        default: begin
          state <= IDLE;
          count <= '0;
          ready <= 1'b1;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cycle_countdown_ctrl.sv
// Self-checking bench for cycle_countdown_ctrl: directed scenarios plus randomized traffic
// against a per-edge behavioural model of the timer rules.
module tb_cycle_countdown_ctrl;
  localparam int W = 5;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] load_val;
  logic         hold;
  logic         abort;
  logic         ready;
  logic         busy;
  logic [W-1:0] count;
  logic         done;

  cycle_countdown_ctrl #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .load_val (load_val),
    .hold     (hold),
    .abort    (abort),
    .ready    (ready),
    .busy     (busy),
    .count    (count),
    .done     (done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // reference: remaining cycles, whether counting, whether the done pulse is showing
  int m_cnt;
  int m_reload;
  bit m_busy;
  bit m_done;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_reload = 0; m_busy = 0; m_done = 0;
  endtask

  task automatic model_edge();
    if (m_done) begin
      m_done = 0;
`ifdef CYCLE_COUNTDOWN_AUTORELOAD_EN
      if (m_reload != 0 && !abort) begin
        m_cnt  = m_reload;
        m_busy = 1;
      end
`endif
    end else if (m_busy) begin
      if (abort) begin
        m_busy = 0;
        m_cnt  = 0;
      end else if (!hold) begin
        m_cnt = m_cnt - 1;
        if (m_cnt == 0) begin
          m_busy = 0;
          m_done = 1;
        end
      end
    end else if (start) begin
      m_cnt    = int'(load_val);
      m_reload = int'(load_val);
      if (m_cnt == 0) m_done = 1;
      else            m_busy = 1;
    end
  endtask

  task automatic check_model();
    check("model_ready", int'(ready), int'(!m_busy && !m_done));
    check("model_busy",  int'(busy),  int'(m_busy));
    check("model_done",  int'(done),  int'(m_done));
    check("model_count", int'(count), m_cnt);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_model();
  endtask

  task automatic drive(input bit s, input int l, input bit h, input bit a);
    start = s; load_val = W'(l); hold = h; abort = a;
  endtask

  task automatic wait_done(input int bound, output int edges);
    edges = 0;
    do begin
      step();
      edges++;
    end while (!done && edges < bound);
    if (!done) check("done_timeout", int'(done), 1);
  endtask

  initial begin
    int e;
    rst = 1'b0;
    drive(0, 0, 0, 0);
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_ready", int'(ready), 1);
    check("rst_busy",  int'(busy),  0);
    check("rst_count", int'(count), 0);
    check("rst_done",  int'(done),  0);
    rst = 1'b1;

    // load 5: count 5..0, single-cycle done, ready one edge later
    drive(1, 5, 0, 0);
    step();
    drive(0, 0, 0, 0);
    check("l5_count0", int'(count), 5);
    for (int i = 1; i <= 5; i++) begin
      step();
      check("l5_count", int'(count), 5 - i);
      check("l5_done", int'(done), int'(i == 5));
    end
    step();
    check("l5_done_off", int'(done), 0);
    check("l5_ready", int'(ready), 1);

    // asynchronous reset in the middle of a run
    drive(1, 5, 0, 0);
    step();
    drive(0, 0, 0, 0);
    step();
    step();
    check("pre_rst_count", int'(count), 3);
    #2 rst = 1'b0;
    #1;
    model_reset();
    check("mid_rst_count", int'(count), 0);
    check("mid_rst_ready", int'(ready), 1);
    check("mid_rst_busy",  int'(busy),  0);
    check("mid_rst_done",  int'(done),  0);
    @(negedge clk) rst = 1'b1;
    drive(1, 2, 0, 0);
    step();
    drive(0, 0, 0, 0);
    wait_done(10, e);
    check("post_rst_edges", e, 2);
    step();

    // load 4 with three held cycles and ignored start pulses
    drive(1, 4, 0, 0);
    step();
    e = 0;
    while (!done && e < 20) begin
      drive(e == 2, 9, (e >= 1 && e < 4), 0);
      step();
      e++;
    end
    drive(0, 0, 0, 0);
    check("hold_edges", e, 7);
    step();

    // load 0: done after first edge, no RUN
    drive(1, 0, 0, 0);
    step();
    drive(0, 0, 0, 0);
    check("l0_done", int'(done), 1);
    check("l0_busy", int'(busy), 0);
    step();
    check("l0_ready", int'(ready), 1);

    // maximum count
    drive(1, 31, 0, 0);
    step();
    drive(0, 0, 0, 0);
    wait_done(40, e);
    check("l31_edges", e, 31);
    step();

    // abort together with hold at count 2
    drive(1, 4, 0, 0);
    step();
    drive(0, 0, 0, 0);
    step();
    step();
    check("ab_pre_count", int'(count), 2);
    drive(0, 0, 1, 1);
    step();
    drive(0, 0, 0, 0);
    check("ab_count", int'(count), 0);
    check("ab_ready", int'(ready), 1);
    check("ab_done",  int'(done),  0);
    step();
    check("ab_no_done", int'(done), 0);

`ifdef CYCLE_COUNTDOWN_AUTORELOAD_EN
    // periodic reload: done every 4 edges, ready held low, abort in DONE returns to IDLE
    drive(1, 3, 0, 0);
    step();
    drive(0, 0, 0, 0);
    wait_done(10, e);
    check("ar_first", e, 3);
    for (int p = 0; p < 2; p++) begin
      wait_done(10, e);
      check("ar_period", e, 4);
      check("ar_ready", int'(ready), 0);
    end
    drive(0, 0, 0, 1);
    step();
    drive(0, 0, 0, 0);
    check("ar_abort_ready", int'(ready), 1);
    check("ar_abort_busy",  int'(busy),  0);
`endif

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      drive($urandom_range(3) == 0,
            ($urandom_range(2) == 0) ? int'($urandom_range(31)) : int'($urandom_range(5)),
            $urandom_range(4) == 0,
            $urandom_range(19) == 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
